// File: rtl/passcode_checker.sv
// Keypad front end of the door lock: collects a BCD code, checks it
// against the stored password and locks the keypad after repeated failures.
module passcode_checker #(
  parameter int          DIGITS      = 4,
  parameter logic [31:0] PASSWORD    = 32'h1234,
  parameter int          MAX_FAIL    = 3,
  parameter int          LOCK_CYCLES = 10000,
  parameter logic [3:0]  KEY_START   = 4'hA,
  parameter logic [3:0]  KEY_ENTER   = 4'hB
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic [1:0] state_in,
  output logic       ps_start,
  output logic       ps_end,
  output logic       err,
  output logic       locked,
  output logic [2:0] digit_cnt
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam int LW = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [1:0] {
    S_WAIT,
    S_ENTRY,
    S_CHECK,
    S_LOCK
  } state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] buf_q, buf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    fail_q, fail_d;
  logic [LW-1:0] lock_q, lock_d;
  logic          start_q, start_d;
  logic          end_q, end_d;
  logic          err_q, err_d;
  logic          locked_q, locked_d;

  logic is_digit;
  logic full;
  logic match;

  assign is_digit = key_code <= 4'd9;
  assign full     = cnt_q == CW'(DIGITS);
  assign match    = full && (buf_q == BW'(PASSWORD));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_WAIT;
      buf_q    <= '0;
      cnt_q    <= '0;
      fail_q   <= '0;
      lock_q   <= '0;
      start_q  <= 1'b0;
      end_q    <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      fail_q   <= fail_d;
      lock_q   <= lock_d;
      start_q  <= start_d;
      end_q    <= end_d;
      err_q    <= err_d;
      locked_q <= locked_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    cnt_d    = cnt_q;
    fail_d   = fail_q;
    lock_d   = lock_q;
    start_d  = 1'b0;
    end_d    = 1'b0;
    err_d    = 1'b0;
    locked_d = locked_q;
    unique case (state_q)
      S_WAIT: begin
        if (key_valid && key_code == KEY_START && state_in == 2'b00) begin
          state_d = S_ENTRY;
          buf_d   = '0;
          cnt_d   = '0;
          start_d = 1'b1;
        end
      end
      S_ENTRY: begin
        if (key_valid) begin
          unique case (1'b1)
            is_digit: begin
              if (!full) begin
                buf_d = (buf_q << 4) | BW'(key_code);
                cnt_d = cnt_q + CW'(1);
              end
            end
            key_code == KEY_START: begin
              buf_d = '0;
              cnt_d = '0;
            end
            key_code == KEY_ENTER: state_d = S_CHECK;
            default: ;
          endcase
        end
      end
      S_CHECK: begin
        if (match) begin
          end_d   = 1'b1;
          fail_d  = '0;
          buf_d   = '0;
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          err_d  = 1'b1;
          fail_d = fail_q + 3'd1;
          if (fail_d == 3'(MAX_FAIL)) begin
            state_d  = S_LOCK;
            lock_d   = '0;
            locked_d = 1'b1;
          end else begin
            buf_d   = '0;
            cnt_d   = '0;
            state_d = S_ENTRY;
          end
        end
      end
      S_LOCK: begin
        // Terminal count releases the keypad; the counter never wraps.
        if (lock_q == LW'(LOCK_CYCLES - 1)) begin
          lock_d   = '0;
          locked_d = 1'b0;
          fail_d   = '0;
          state_d  = S_WAIT;
        end else begin
          lock_d = lock_q + LW'(1);
        end
      end
      default: state_d = S_WAIT;
    endcase
  end

  assign ps_start  = start_q;
  assign ps_end    = end_q;
  assign err       = err_q;
  assign locked    = locked_q;
  assign digit_cnt = 3'(cnt_q);

endmodule

// File: tb/tb_passcode_checker.sv
// Bench for passcode_checker: directed and random key sessions compared
// cycle by cycle against a queue-based model of the keypad rules.
module tb_passcode_checker;

  localparam int PW   = 'h1234;
  localparam int MAXF = 3;
  localparam int LCYC = 10000;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_code;
  logic [1:0] state_in;
  logic       ps_start;
  logic       ps_end;
  logic       err;
  logic       locked;
  logic [2:0] digit_cnt;

  int n_vec = 0;
  int n_bad = 0;

  bit m_open;
  bit m_chk;
  int m_dig[$];
  int m_fail;
  int m_lock;
  bit e_ps;
  bit e_pe;
  bit e_err;

  passcode_checker dut (
    .clk      (clk),
    .rst      (rst),
    .key_valid(key_valid),
    .key_code (key_code),
    .state_in (state_in),
    .ps_start (ps_start),
    .ps_end   (ps_end),
    .err      (err),
    .locked   (locked),
    .digit_cnt(digit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_open = 0;
    m_chk  = 0;
    m_dig.delete();
    m_fail = 0;
    m_lock = 0;
    e_ps   = 0;
    e_pe   = 0;
    e_err  = 0;
  endfunction

  function automatic void model_step(bit v, logic [3:0] k, logic [1:0] st);
    int val;
    e_ps  = 0;
    e_pe  = 0;
    e_err = 0;
    if (m_lock > 0) begin
      m_lock--;
      if (m_lock == 0) m_fail = 0;
    end else if (m_chk) begin
      m_chk = 0;
      val = 0;
      foreach (m_dig[i]) val = val * 16 + m_dig[i];
      if (m_dig.size() == 4 && val == PW) begin
        e_pe   = 1;
        m_fail = 0;
        m_open = 0;
        m_dig.delete();
      end else begin
        e_err = 1;
        m_fail++;
        if (m_fail == MAXF) begin
          m_lock = LCYC;
          m_open = 0;
        end else begin
          m_dig.delete();
        end
      end
    end else if (m_open) begin
      if (v) begin
        if (k <= 9) begin
          if (m_dig.size() < 4) m_dig.push_back(int'(k));
        end else if (k == 4'hA) begin
          m_dig.delete();
        end else if (k == 4'hB) begin
          m_chk = 1;
        end
      end
    end else if (v && k == 4'hA && st == 2'b00) begin
      m_open = 1;
      m_dig.delete();
      e_ps = 1;
    end
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".ps_start"}, 8'(ps_start), 8'(e_ps));
    chk({tag, ".ps_end"}, 8'(ps_end), 8'(e_pe));
    chk({tag, ".err"}, 8'(err), 8'(e_err));
    chk({tag, ".locked"}, 8'(locked), 8'(m_lock > 0));
    chk({tag, ".digit_cnt"}, 8'(digit_cnt), 8'(m_dig.size()));
  endtask

  task automatic tick(input string tag, input bit v, input logic [3:0] k);
    key_valid = v;
    key_code  = k;
    @(posedge clk);
    model_step(v, k, state_in);
    #1;
    check_all(tag);
  endtask

  task automatic press(input string tag, input logic [3:0] k);
    tick(tag, 1'b1, k);
    tick(tag, 1'b0, 4'h0);
    tick(tag, 1'b0, 4'h0);
  endtask

  task automatic code(input string tag, input int d[$]);
    press(tag, 4'hA);
    foreach (d[i]) press(tag, 4'(d[i]));
    press(tag, 4'hB);
  endtask

  task automatic do_reset(input string tag);
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(posedge clk);
    #1;
    check_all(tag);
    #2;
    rst = 1'b1;
  endtask

  initial begin
    int wrong[$];
    int seq[$];
    int n;
    rst       = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'h0;
    state_in  = 2'b00;
    model_reset();
    #12;
    check_all("reset");
    #10;
    rst = 1'b1;
    tick("idle", 1'b0, 4'h0);

    code("t1_ok", '{1, 2, 3, 4});
    code("t2_bad", '{1, 2, 3, 5});
    foreach (seq[i]) seq.delete();
    press("t2_retry", 4'h1);
    press("t2_retry", 4'h2);
    press("t2_retry", 4'h3);
    press("t2_retry", 4'h4);
    press("t2_retry", 4'hB);

    wrong = '{9, 9, 9, 9};
    code("t3_w1", wrong);
    code("t3_w2", '{1, 2, 3});
    code("t3_w3", '{4, 3, 2, 1});
    for (int i = 0; i < LCYC + 5; i++)
      tick("t3_lock", ($urandom % 3) == 0, 4'($urandom));
    press("t3_after", 4'hA);
    press("t3_after", 4'hB);
    press("t3_after", 4'hC);
    code("t3_ok", '{1, 2, 3, 4});

    code("t4_extra", '{1, 2, 3, 4, 9});
    code("t4_short", '{1, 2, 3});
    code("t4_ok", '{1, 2, 3, 4});

    state_in = 2'b01;
    press("t5_busy", 4'hA);
    state_in = 2'b00;
    press("t5_rst", 4'hA);
    press("t5_rst", 4'h1);
    press("t5_rst", 4'h2);
    code("t5_restart", '{1, 2, 3, 4});
    press("t5_cf", 4'hA);
    press("t5_cf", 4'hC);
    press("t5_cf", 4'hF);
    press("t5_cf", 4'h1);
    press("t5_cf", 4'hB);
    tick("t5_cf", 1'b0, 4'h0);
    code("t5_ok", '{1, 2, 3, 4});

    press("t6_mid", 4'hA);
    press("t6_mid", 4'h1);
    press("t6_mid", 4'h2);
    do_reset("t6_rst_entry");
    foreach (wrong[i]) press("t6_noa", 4'(i + 1));
    press("t6_noa", 4'hB);
    code("t6_w1", '{5});
    code("t6_w2", '{5});
    code("t6_w3", '{5});
    for (int i = 0; i < 50; i++) tick("t6_lock", 1'b0, 4'h0);
    do_reset("t6_rst_lock");
    for (int i = 0; i < 4; i++) press("t6_post", 4'(i + 1));
    press("t6_post", 4'hB);
    code("t6_ok", '{1, 2, 3, 4});

    for (int s = 0; s < 60; s++) begin
      seq.delete();
      state_in = (($urandom % 8) == 0) ? 2'($urandom_range(1, 2)) : 2'b00;
      if (($urandom % 4) != 0) begin
        seq = '{1, 2, 3, 4};
      end else begin
        n = $urandom_range(2, 5);
        for (int i = 0; i < n; i++) seq.push_back($urandom_range(0, 9));
      end
      tick("rnd", 1'b1, 4'hA);
      foreach (seq[i]) begin
        if (($urandom % 6) == 0) tick("rnd", 1'b1, 4'($urandom_range(10, 15)));
        tick("rnd", 1'b1, 4'(seq[i]));
        if (($urandom % 2) == 0) tick("rnd", 1'b0, 4'h0);
      end
      tick("rnd", 1'b1, 4'hB);
      for (int g = $urandom_range(0, 3); g >= 0; g--) tick("rnd", 1'b0, 4'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
